// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier controller. It reuses one external
// combinational 8x8 multiplier, feeding it one digit pair per cycle and accumulating the partial products.
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic [7:0]         mul_a,
    output logic [7:0]         mul_b,
    input  logic [15:0]        mul_out
);

    localparam int D  = WIDTH / 8;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    out_q, out_d;
    logic [CW-1:0]    i_q, i_d;
    logic [CW-1:0]    j_q, j_d;

    logic          last_digit;
    logic [PW-1:0] pp;
    logic [PW-1:0] acc_sum;

    assign last_digit = (i_q == CW'(D - 1)) && (j_q == CW'(D - 1));
    assign pp         = PW'(mul_out) << (8 * (32'(i_q) + 32'(j_q)));
    assign acc_sum    = acc_q + pp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_RUN: begin
                busy  = 1'b1;
                mul_a = a_q[8*i_q +: 8];
                mul_b = b_q[8*j_q +: 8];
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        out_d = out_q;
        i_d   = i_q;
        j_d   = j_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                // j is the inner digit index; i advances when j wraps
                if (j_q == CW'(D - 1)) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                if (last_digit) begin
                    out_d = acc_sum;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            out_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            out_q <= out_d;
            i_q   <= i_d;
            j_q   <= j_d;
        end
    end

    assign out = out_q;

endmodule
